// File: rtl/mips32_loader.sv
// Host-side loader for a MIPS32 core: streams words into CPU memory, starts the
// core and waits for halt with a timeout, then streams memory words back out.
module mips32_loader #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int RUN_TIMEOUT = 1000
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_start,
  input  logic              cpu_halted,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TW = (RUN_TIMEOUT > 1) ? $clog2(RUN_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0]     TO_LAST = TW'(RUN_TIMEOUT - 1);
  localparam logic [TW-1:0]     T_ONE   = TW'(1);
  localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_ZERO  = '0;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN_START, S_RUN_WAIT, S_DUMP_RD, S_DUMP_WAIT, S_DUMP_OUT
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_remaining;
  logic [TW-1:0]     r_timeout;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_done;
  logic              r_err;
  logic              r_cpu_start;
  logic              w_last;

  assign w_last = (r_remaining == A_ONE);

  // Handshake strobes decode straight from the state register.
  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign wr_ready  = (r_state == S_LOAD);
  assign rd_valid  = (r_state == S_DUMP_OUT);
  assign mem_re    = (r_state == S_DUMP_RD);
  assign mem_we    = (r_state == S_LOAD) && wr_valid;
  assign mem_addr  = r_addr;
  assign mem_wdata = (r_state == S_LOAD) ? wr_data : '0;
  assign rd_data   = r_rd_data;
  assign cpu_start = r_cpu_start;
  assign done      = r_done;
  assign err       = r_err;

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_timeout   <= '0;
      r_rd_data   <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cpu_start <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cpu_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_addr      <= cmd_addr;
            r_remaining <= cmd_len;
            case (cmd_op)
              2'b00: if (cmd_len == A_ZERO) r_done <= 1'b1; else r_state <= S_LOAD;
              2'b01: begin
                r_state     <= S_RUN_START;
                r_cpu_start <= 1'b1;
              end
              2'b10: if (cmd_len == A_ZERO) r_done <= 1'b1; else r_state <= S_DUMP_RD;
              default: r_err <= 1'b1;
            endcase
          end
        end
        S_LOAD: begin
          if (wr_valid) begin
            r_addr      <= r_addr + A_ONE;
            r_remaining <= r_remaining - A_ONE;
            if (w_last) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        // cpu_start is high during this state; the core drops any stale halt here.
        S_RUN_START: begin
          r_state   <= S_RUN_WAIT;
          r_timeout <= '0;
        end
        S_RUN_WAIT: begin
          if (cpu_halted) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else if (r_timeout == TO_LAST) begin
            r_state <= S_IDLE;
            r_err   <= 1'b1;
          end else begin
            r_timeout <= r_timeout + T_ONE;
          end
        end
        S_DUMP_RD:   r_state <= S_DUMP_WAIT;
        S_DUMP_WAIT: begin
          r_rd_data <= mem_rdata;
          r_state   <= S_DUMP_OUT;
        end
        S_DUMP_OUT: begin
          if (rd_ready) begin
            r_addr      <= r_addr + A_ONE;
            r_remaining <= r_remaining - A_ONE;
            if (w_last) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_DUMP_RD;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_loader.sv
// Directed bench for mips32_loader with a memory model, a simple CPU model and
// scoreboard queues for memory writes, memory reads and dumped words.
module tb_mips32_loader;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [9:0]  cmd_addr;
  logic [9:0]  cmd_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        mem_we;
  logic        mem_re;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        cpu_start;
  logic        cpu_halted;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk1 = ~clk1;

  mips32_loader #(.ADDR_W(10), .DATA_W(32), .RUN_TIMEOUT(1000)) dut (
    .clk1(clk1), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_start(cpu_start), .cpu_halted(cpu_halted),
    .busy(busy), .done(done), .err(err)
  );

  // Memory with one-cycle read latency, plus a CPU stand-in that halts 40
  // cycles after cpu_start and stores mem[120]+45 into mem[121].
  logic [31:0] mem [0:1023];
  int          halt_cnt = 0;
  bit          halt_en  = 1'b1;

  always @(posedge clk1) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (cpu_start) begin
      cpu_halted <= 1'b0;
      halt_cnt   <= halt_en ? 40 : 0;
    end else if (halt_cnt != 0) begin
      halt_cnt <= halt_cnt - 1;
      if (halt_cnt == 1) begin
        cpu_halted <= 1'b1;
        mem[121]   <= mem[120] + 32'd45;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0, we_cnt = 0, re_cnt = 0, done_cnt = 0, err_cnt = 0, start_cnt = 0;
  int done_cyc = 0, err_cyc = 0, start_cyc = 0, halt_cyc = 0;
  logic        prev_halted = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = '0;

  logic [9:0]  exp_wa[$];
  logic [31:0] exp_wd[$];
  logic [9:0]  exp_ra[$];
  logic [31:0] exp_rd[$];
  logic [31:0] words[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pops and per-cycle invariants.
  initial begin
    forever begin
      @(negedge clk1);
      cyc++;
      chk("we_re_exclusive", 32'(mem_we & mem_re), 32'd0);
      chk("done_err_exclusive", 32'(done & err), 32'd0);
      if (mem_we) begin
        we_cnt++;
        chk("we_expected", 32'(exp_wa.size() != 0), 32'd1);
        if (exp_wa.size() != 0) begin
          chk("we_addr", 32'(mem_addr), 32'(exp_wa.pop_front()));
          chk("we_data", mem_wdata, exp_wd.pop_front());
        end
      end
      if (mem_re) begin
        re_cnt++;
        chk("re_expected", 32'(exp_ra.size() != 0), 32'd1);
        if (exp_ra.size() != 0) chk("re_addr", 32'(mem_addr), 32'(exp_ra.pop_front()));
      end
      if (prev_hold) begin
        chk("rd_hold_valid", 32'(rd_valid), 32'd1);
        chk("rd_hold_data", rd_data, prev_data);
      end
      if (rd_valid && rd_ready) begin
        chk("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
        if (exp_rd.size() != 0) begin
          logic [31:0] e;
          e = exp_rd.pop_front();
          chk("rd_data", rd_data, e);
          $display("dump word %08h", rd_data);
        end
      end
      prev_hold = rd_valid & ~rd_ready;
      prev_data = rd_data;
      if (cpu_start) begin start_cnt++; start_cyc = cyc; end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (err) begin err_cnt++; err_cyc = cyc; end
      if (cpu_halted && !prev_halted) halt_cyc = cyc;
      prev_halted = cpu_halted;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_cpu_start"}, 32'(cpu_start), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_re"}, 32'(mem_re), 32'd0);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_rd_data"}, rd_data, 32'd0);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [9:0] a, input logic [9:0] l);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = l;
    @(negedge clk1);
    while (!cmd_ready && n < 50) begin n++; @(negedge clk1); end
    chk("cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk1); #1;
    cmd_valid = 1'b0;
    $display("cmd op=%0d addr=%0d len=%0d accepted", op, a, l);
  endtask

  // Streams the words queue; abort_at >= 0 pulls rst_n low with that word.
  task automatic do_load(input logic [9:0] a, input int abort_at);
    int nw = words.size();
    send_cmd(2'b00, a, 10'(nw));
    for (int i = 0; i < nw; i++) begin
      int n = 0;
      if (i == abort_at) rst_n = 1'b0;
      wr_valid = 1'b1;
      wr_data  = words[i];
      exp_wa.push_back(a + 10'(i));
      exp_wd.push_back(words[i]);
      @(negedge clk1);
      while (!wr_ready && n < 20) begin n++; @(negedge clk1); end
      chk("wr_ready", 32'(wr_ready), 32'd1);
      @(posedge clk1); #1;
      if (i == abort_at) break;
    end
    wr_valid = 1'b0;
  endtask

  task automatic finish_op(input string tag, input int bound, input bit exp_done);
    bit d = 1'b0, e = 1'b0;
    int n = 0;
    while (n < bound) begin
      @(negedge clk1);
      n++;
      if (done || err) begin d = done; e = err; break; end
    end
    chk({tag, "_done"}, 32'(d), 32'(exp_done));
    chk({tag, "_err"}, 32'(e), 32'(!exp_done));
    @(negedge clk1);
    chk({tag, "_single_pulse"}, 32'(done | err), 32'd0);
    @(posedge clk1); #1;
    $display("%s finished done=%0d err=%0d", tag, d, e);
  endtask

  initial begin
    int we0, re0, st0, d0, e0, n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0; cpu_halted = 1'b0;
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    check_reset_outs("reset");
    @(posedge clk1); #1;
    rst_n = 1'b1;
    @(negedge clk1);
    chk("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);
    @(posedge clk1); #1;

    // Program image at 0..7
    we0 = we_cnt;
    words = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
              32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};
    do_load(10'd0, -1);
    finish_op("load8", 5, 1'b1);
    chk("load8_we_count", 32'(we_cnt - we0), 32'd8);

    // Zero-length LOAD and DUMP complete at once with no memory access
    we0 = we_cnt; re0 = re_cnt;
    send_cmd(2'b00, 10'd5, 10'd0);
    finish_op("load_len0", 1, 1'b1);
    send_cmd(2'b10, 10'd5, 10'd0);
    finish_op("dump_len0", 1, 1'b1);
    chk("len0_mem_access", 32'(we_cnt - we0 + re_cnt - re0), 32'd0);

    // Operand at 120, run until the CPU halts
    words = '{32'd85};
    do_load(10'd120, -1);
    finish_op("load_operand", 5, 1'b1);
    st0 = start_cnt; e0 = err_cnt;
    send_cmd(2'b01, 10'd0, 10'd0);
    finish_op("run_halt", 100, 1'b1);
    chk("run_start_pulses", 32'(start_cnt - st0), 32'd1);
    chk("run_done_after_halt", 32'(done_cyc - halt_cyc), 32'd1);
    chk("run_no_err", 32'(err_cnt - e0), 32'd0);

    // Dump the operand and the result with random back-pressure
    exp_ra.push_back(10'd120); exp_ra.push_back(10'd121);
    exp_rd.push_back(32'd85);  exp_rd.push_back(32'd130);
    d0 = done_cnt; e0 = err_cnt; n = 0;
    send_cmd(2'b10, 10'd120, 10'd2);
    while (done_cnt == d0 && err_cnt == e0 && n < 300) begin
      @(posedge clk1); #1;
      rd_ready = 1'($urandom_range(0, 1));
      n++;
    end
    rd_ready = 1'b0;
    chk("dump_done", 32'(done_cnt - d0), 32'd1);
    chk("dump_no_err", 32'(err_cnt - e0), 32'd0);
    chk("dump_rd_all_seen", 32'(exp_rd.size()), 32'd0);
    chk("dump_re_all_seen", 32'(exp_ra.size()), 32'd0);
    @(posedge clk1); #1;

    // Timeout with halt withheld; the halt level left over must not count
    halt_en = 1'b0;
    d0 = done_cnt;
    send_cmd(2'b01, 10'd0, 10'd0);
    finish_op("run_timeout", 1200, 1'b0);
    chk("timeout_latency", 32'(err_cyc - start_cyc), 32'd1001);
    chk("timeout_no_done", 32'(done_cnt - d0), 32'd0);
    @(negedge clk1);
    chk("timeout_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk1); #1;
    halt_en = 1'b1;

    // Address wrap on LOAD and DUMP
    words = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2};
    do_load(10'd1022, -1);
    finish_op("load_wrap", 5, 1'b1);
    exp_ra.push_back(10'd1023); exp_ra.push_back(10'd0); exp_ra.push_back(10'd1);
    exp_rd.push_back(32'hB1B1B1B1); exp_rd.push_back(32'hC2C2C2C2);
    exp_rd.push_back(32'h0c631800);
    rd_ready = 1'b1;
    send_cmd(2'b10, 10'd1023, 10'd3);
    finish_op("dump_wrap", 50, 1'b1);
    rd_ready = 1'b0;
    chk("wrap_rd_all_seen", 32'(exp_rd.size()), 32'd0);

    // Reserved opcode
    we0 = we_cnt; re0 = re_cnt; st0 = start_cnt;
    send_cmd(2'b11, 10'd7, 10'd4);
    finish_op("op_reserved", 1, 1'b0);
    chk("reserved_no_mem", 32'(we_cnt - we0 + re_cnt - re0), 32'd0);
    chk("reserved_no_start", 32'(start_cnt - st0), 32'd0);

    // Reset on the third word of an 8-word LOAD
    d0 = done_cnt; e0 = err_cnt;
    words = '{32'h11110000, 32'h11110001, 32'h11110002, 32'h11110003,
              32'h11110004, 32'h11110005, 32'h11110006, 32'h11110007};
    do_load(10'd200, 2);
    @(negedge clk1);
    check_reset_outs("abort");
    @(posedge clk1); #1;
    rst_n = 1'b1;
    @(negedge clk1);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_no_err", 32'(err_cnt - e0), 32'd0);
    chk("abort_writes_seen", 32'(exp_wa.size()), 32'd0);
    @(posedge clk1); #1;

    words = '{32'h22220000, 32'h22220001};
    do_load(10'd300, -1);
    finish_op("load_after_abort", 5, 1'b1);
    exp_ra.push_back(10'd200); exp_ra.push_back(10'd201); exp_ra.push_back(10'd202);
    exp_rd.push_back(32'h11110000); exp_rd.push_back(32'h11110001);
    exp_rd.push_back(32'h11110002);
    rd_ready = 1'b1;
    send_cmd(2'b10, 10'd200, 10'd3);
    finish_op("dump_retained", 50, 1'b1);
    rd_ready = 1'b0;
    chk("retained_rd_all_seen", 32'(exp_rd.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
